// File: rtl/usb11_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb11_pkg
//  Description : Shared types and constants for the usb11_mctrl host command
//                sequencer: FSM state encoding, command word bit positions,
//                response type codes and the fixed handshake PID bytes.
//  Revision    : 1.0  initial release
// ============================================================================
package usb11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_DECODE   = 4'd2,
        ST_WAIT_SOF = 4'd3,
        ST_WAIT_TX  = 4'd4,
        ST_WAIT_RX  = 4'd5,
        ST_ACK_S    = 4'd6,
        ST_ACK_SW   = 4'd7,
        ST_ACK_P    = 4'd8,
        ST_ACK_PW   = 4'd9
    } state_t;

    // Command word bit positions
    localparam int c_BIT_RST     = 0;
    localparam int c_BIT_ENA     = 1;
    localparam int c_BIT_RDLINES = 9;
    localparam int c_BIT_SETRE   = 10;
    localparam int c_BIT_AUTOACK = 12;
    localparam int c_BIT_LAST    = 13;
    localparam int c_BIT_BYTEOUT = 14;
    localparam int c_BIT_PKT     = 15;

    // Response word type codes, bits [15:14]
    localparam logic [1:0] c_RSP_DATA  = 2'b00;
    localparam logic [1:0] c_RSP_LINES = 2'b01;
    localparam logic [1:0] c_RSP_TMO   = 2'b10;

    // Handshake bytes sent after a successful IN data stage
    localparam logic [7:0] c_PID_SYNC = 8'h80;
    localparam logic [7:0] c_PID_ACK  = 8'hD2;

endpackage : usb11_pkg
`default_nettype wire

// File: rtl/usb11_sfifo.sv
`default_nettype none
// ============================================================================
//  Module      : usb11_sfifo
//  Description : Synchronous first-word-fall-through FIFO, depth 2**AW.
//                Push on full and pop on empty are ignored; a simultaneous
//                push and pop on a non-empty FIFO keeps the count unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module usb11_sfifo #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_full,
    input  logic          i_rd,
    output logic [DW-1:0] o_rdata,
    output logic          o_empty
);

    localparam int c_DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [0:c_DEPTH-1];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == c_DEPTH[AW:0]);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_wr & ~o_full;
    assign w_pop   = i_rd & ~o_empty;
    // Head is forced to zero while empty so the output is defined from reset
    assign o_rdata = o_empty ? '0 : r_mem[r_rp];

    // Storage array: written on accepted pushes, never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : usb11_sfifo
`default_nettype wire

// File: rtl/usb11_mctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb11_mctrl
//  Description : N-port low-speed USB host command sequencer. Executes 16-bit
//                commands from a command FIFO, drives a shared serializer,
//                collects received bytes / line states into a response FIFO,
//                holds EOF-aligned per-port reset/enable and auto-ACKs IN data.
//                Optional feature macro: USB11_MCTRL_RXTO_EN (WAIT_RX timeout).
//  Revision    : 1.0  initial release
// ============================================================================
module usb11_mctrl
    import usb11_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int CHW    = 1,
    parameter int CMD_AW = 5,
    parameter int RSP_AW = 5,
    parameter int RX_TO  = 8000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    i_cmd_data,
    input  logic [CHW-1:0] i_cmd_chan,
    input  logic           i_cmd_wr,
    output logic           o_cmd_full,
    output logic [15:0]    o_rsp_data,
    output logic           o_rsp_rdy,
    input  logic           i_rsp_rd,
    output logic           o_rsp_ovf,
    output logic [7:0]     o_tx_byte,
    output logic           o_tx_wr,
    output logic           o_tx_last,
    input  logic           i_tx_next,
    input  logic           i_tx_pkt_end,
    input  logic           i_tx_busy,
    input  logic           i_frame_start,
    input  logic           i_eof,
    input  logic [7:0]     i_rx_data,
    input  logic           i_rx_rdy,
    input  logic           i_rx_end,
    output logic [CHW-1:0] o_chan_sel,
    input  logic [NCH-1:0] i_line_dp,
    input  logic [NCH-1:0] i_line_dm,
    output logic [NCH-1:0] o_port_rst,
    output logic [NCH-1:0] o_port_ena
);

    localparam logic [15:0] c_RX_TO = 16'(RX_TO);

    state_t           r_state, w_next;
    logic [15:0]      r_cmd;
    logic [CHW-1:0]   r_chan;
    logic [NCH-1:0]   r_pend_rst, r_pend_ena;
    logic [NCH-1:0]   r_port_rst, r_port_ena;
    logic             r_ovf;

    logic [CHW+15:0]  w_cmd_head;
    logic             w_cmd_empty, w_cmd_pop;
    logic             w_rsp_push, w_rsp_full, w_rsp_empty, w_rsp_lost;
    logic [15:0]      w_rsp_word;
    logic             w_lines_req, w_rx_req, w_tmo_req, w_to_hit;
    logic [11:0]      w_lines;
    logic [5:0]       w_chan6;
    logic [7:0]       w_tx_byte;
    logic             w_tx_wr, w_tx_last;
    logic             w_unused_cmd;

    assign w_chan6      = 6'(r_chan);
    assign w_unused_cmd = r_cmd[8] ^ r_cmd[11];

    usb11_sfifo #(.DW(16 + CHW), .AW(CMD_AW)) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (i_cmd_wr),
        .i_wdata ({i_cmd_chan, i_cmd_data}),
        .o_full  (o_cmd_full),
        .i_rd    (w_cmd_pop),
        .o_rdata (w_cmd_head),
        .o_empty (w_cmd_empty)
    );

    usb11_sfifo #(.DW(16), .AW(RSP_AW)) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_rsp_push),
        .i_wdata (w_rsp_word),
        .o_full  (w_rsp_full),
        .i_rd    (i_rsp_rd),
        .o_rdata (o_rsp_data),
        .o_empty (w_rsp_empty)
    );

`ifdef USB11_MCTRL_RXTO_EN
    logic [15:0] r_to_cnt;
    assign w_to_hit = (r_to_cnt == c_RX_TO - 16'd1);

    // Timeout counter: held at zero outside WAIT_RX, so it restarts on each entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_to_cnt <= '0;
        else if (r_state != ST_WAIT_RX) r_to_cnt <= '0;
        else                           r_to_cnt <= r_to_cnt + 16'd1;
    end
`else
    logic w_unused_rxto;
    assign w_to_hit      = 1'b0;
    assign w_unused_rxto = ^c_RX_TO;  // timeout length has no consumer here
`endif

    // Line-state snapshot: {dp,dm} pair of port i at bits [2i+1:2i]
    always_comb begin
        w_lines = '0;
        for (int i = 0; i < NCH; i++) begin
            w_lines[2*i+1] = i_line_dp[i];
            w_lines[2*i]   = i_line_dm[i];
        end
    end

    // Next-state and serializer strobes
    always_comb begin
        w_next      = r_state;
        w_cmd_pop   = 1'b0;
        w_tx_wr     = 1'b0;
        w_tx_byte   = r_cmd[7:0];
        w_tx_last   = 1'b0;
        w_lines_req = 1'b0;
        w_rx_req    = 1'b0;
        w_tmo_req   = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_cmd_empty) w_next = ST_LOAD;
            ST_LOAD: begin
                w_cmd_pop = 1'b1;
                w_next    = ST_DECODE;
            end
            ST_DECODE: begin
                w_lines_req = r_cmd[c_BIT_RDLINES];
                if (r_cmd[c_BIT_PKT]) begin
                    w_next = ST_WAIT_SOF;
                end else if (r_cmd[c_BIT_BYTEOUT]) begin
                    w_tx_wr   = 1'b1;
                    w_tx_last = r_cmd[c_BIT_LAST];
                    w_next    = ST_WAIT_TX;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_SOF: if (i_frame_start) begin
                w_tx_wr   = 1'b1;
                w_tx_last = r_cmd[c_BIT_LAST];
                w_next    = ST_WAIT_TX;
            end
            ST_WAIT_TX: if (i_tx_next || i_tx_pkt_end) begin
                w_next = r_cmd[c_BIT_AUTOACK] ? ST_WAIT_RX : ST_IDLE;
            end
            ST_WAIT_RX: begin
                // Receive side is deaf while our own serializer drives the bus
                w_rx_req = i_rx_rdy & ~i_tx_busy;
                if (i_eof)                       w_next = ST_IDLE;
                else if (i_rx_end && !i_tx_busy) w_next = ST_ACK_S;
                else if (w_to_hit) begin
                    w_tmo_req = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_ACK_S: begin
                w_tx_wr   = 1'b1;
                w_tx_byte = c_PID_SYNC;
                w_next    = ST_ACK_SW;
            end
            ST_ACK_SW: if (i_tx_next) w_next = ST_ACK_P;
            ST_ACK_P: begin
                w_tx_wr   = 1'b1;
                w_tx_byte = c_PID_ACK;
                w_tx_last = 1'b1;
                w_next    = ST_ACK_PW;
            end
            ST_ACK_PW: if (i_tx_pkt_end) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Response arbitration: received data beats timeout beats line snapshot
    always_comb begin
        w_rsp_push = 1'b0;
        w_rsp_word = '0;
        w_rsp_lost = 1'b0;
        if (w_rx_req) begin
            w_rsp_push = 1'b1;
            w_rsp_word = {c_RSP_DATA, w_chan6, i_rx_data};
            w_rsp_lost = w_lines_req | w_tmo_req;
        end else if (w_tmo_req) begin
            w_rsp_push = 1'b1;
            w_rsp_word = {c_RSP_TMO, w_chan6, 8'h00};
            w_rsp_lost = w_lines_req;
        end else if (w_lines_req) begin
            w_rsp_push = 1'b1;
            w_rsp_word = {c_RSP_LINES, 2'b00, w_lines};
        end
    end

    // State register, command latch, overflow flag and port control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_chan     <= '0;
            r_pend_rst <= '0;
            r_pend_ena <= '0;
            r_port_rst <= '0;
            r_port_ena <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_LOAD) begin
                r_cmd  <= w_cmd_head[15:0];
                r_chan <= w_cmd_head[16 +: CHW];
            end
            if (r_state == ST_DECODE && r_cmd[c_BIT_SETRE]) begin
                for (int i = 0; i < NCH; i++) begin
                    if (r_chan == CHW'(i)) begin
                        r_pend_rst[i] <= r_cmd[c_BIT_RST];
                        r_pend_ena[i] <= r_cmd[c_BIT_ENA];
                    end
                end
            end
            // Port controls only ever change on the frame boundary
            if (i_eof) begin
                r_port_rst <= r_pend_rst;
                r_port_ena <= r_pend_ena;
            end
            if ((w_rsp_push && w_rsp_full) || w_rsp_lost) r_ovf <= 1'b1;
        end
    end

    assign o_rsp_rdy  = ~w_rsp_empty;
    assign o_rsp_ovf  = r_ovf;
    assign o_tx_byte  = w_tx_byte;
    assign o_tx_wr    = w_tx_wr;
    assign o_tx_last  = w_tx_last;
    assign o_chan_sel = r_chan;
    assign o_port_rst = r_port_rst;
    assign o_port_ena = r_port_ena;

endmodule : usb11_mctrl
`default_nettype wire

// File: tb/tb_usb11_mctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb11_mctrl
//  Description : Self-checking bench for usb11_mctrl (NCH=2, RX_TO=100).
//                A small serializer model answers tx_wr strobes; a reference
//                model of pending/port registers and line words checks a
//                randomized command stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb11_mctrl;

    localparam int NCH = 2;
    localparam int CHW = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [15:0]    cmd_data;
    logic [CHW-1:0] cmd_chan;
    logic           cmd_wr, cmd_full;
    logic [15:0]    rsp_data;
    logic           rsp_rdy, rsp_rd, rsp_ovf;
    logic [7:0]     tx_byte;
    logic           tx_wr, tx_last, tx_next, tx_pkt_end, tx_busy;
    logic           ser_busy, force_busy;
    logic           frame_start, eof;
    logic [7:0]     rx_data;
    logic           rx_rdy, rx_end;
    logic [CHW-1:0] chan_sel;
    logic [NCH-1:0] line_dp, line_dm, port_rst, port_ena;

    assign tx_busy = ser_busy | force_busy;

    always #5 clk = ~clk;

    usb11_mctrl #(.NCH(NCH), .CHW(CHW), .CMD_AW(5), .RSP_AW(5), .RX_TO(100)) dut (
        .clk(clk), .reset(reset),
        .i_cmd_data(cmd_data), .i_cmd_chan(cmd_chan), .i_cmd_wr(cmd_wr), .o_cmd_full(cmd_full),
        .o_rsp_data(rsp_data), .o_rsp_rdy(rsp_rdy), .i_rsp_rd(rsp_rd), .o_rsp_ovf(rsp_ovf),
        .o_tx_byte(tx_byte), .o_tx_wr(tx_wr), .o_tx_last(tx_last),
        .i_tx_next(tx_next), .i_tx_pkt_end(tx_pkt_end), .i_tx_busy(tx_busy),
        .i_frame_start(frame_start), .i_eof(eof),
        .i_rx_data(rx_data), .i_rx_rdy(rx_rdy), .i_rx_end(rx_end),
        .o_chan_sel(chan_sel), .i_line_dp(line_dp), .i_line_dm(line_dm),
        .o_port_rst(port_rst), .o_port_ena(port_ena)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic [7:0] b; logic l; } tx_t;
    tx_t txq[$];

    typedef struct { logic [1:0] dp; logic [1:0] dm; logic [15:0] exp; } lv_t;
    lv_t lv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out, event never seen", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_cmd(input logic [15:0] d, input logic [CHW-1:0] c);
        int k = 0;
        while (cmd_full && k < 200) begin tick(); k++; end
        if (cmd_full) timeout_fail("cmd_full wait");
        cmd_data = d; cmd_chan = c; cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic pop_rsp(input string name, input logic [15:0] exp);
        int k = 0;
        while (!rsp_rdy && k < 200) begin tick(); k++; end
        if (!rsp_rdy) timeout_fail(name);
        else begin
            check(name, rsp_data, exp);
            rsp_rd = 1'b1;
            tick();
            rsp_rd = 1'b0;
        end
    endtask

    task automatic wait_txq(input int n, input string name);
        int k = 0;
        while (txq.size() < n && k < 100) begin tick(); k++; end
        if (txq.size() < n) timeout_fail(name);
    endtask

    task automatic pulse_eof();
        eof = 1'b1; tick(); eof = 1'b0;
    endtask

    task automatic pulse_sof();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
    endtask

    // Expected line-state word: type 01, port i contributes dp*2+dm at bit 2i
    function automatic logic [15:0] lines_word(input logic [1:0] dp, input logic [1:0] dm);
        int w = 32'h4000;
        for (int i = 0; i < NCH; i++) w += (int'(dp[i]) * 2 + int'(dm[i])) << (2 * i);
        return 16'(w);
    endfunction

    // Log every serializer load strobe
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr === 1'b1) txq.push_back('{tx_byte, tx_last});
        end
    end

    // Serializer model: acknowledges each byte two cycles after load
    initial begin
        logic l;
        ser_busy = 1'b0; tx_next = 1'b0; tx_pkt_end = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_wr === 1'b1) begin
                l = tx_last;
                ser_busy = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                if (l) tx_pkt_end = 1'b1; else tx_next = 1'b1;
                @(posedge clk);
                #1;
                tx_next = 1'b0; tx_pkt_end = 1'b0;
                if (l) ser_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] m_pend_rst, m_pend_ena, m_port_rst, m_port_ena;
        logic [1:0] dp, dm;
        logic [CHW-1:0] ch;
        logic r, e, s;
        logic [15:0] cw;
        int cnt, op, n0;

        lv[0] = '{2'b01, 2'b10, 16'h4006};
        lv[1] = '{2'b00, 2'b00, 16'h4000};
        lv[2] = '{2'b11, 2'b11, 16'h400F};
        lv[3] = '{2'b10, 2'b01, 16'h4009};
        lv[4] = '{2'b11, 2'b00, 16'h400A};

        reset = 1'b1; cmd_data = '0; cmd_chan = '0; cmd_wr = 1'b0; rsp_rd = 1'b0;
        force_busy = 1'b0; frame_start = 1'b0; eof = 1'b0;
        rx_data = '0; rx_rdy = 1'b0; rx_end = 1'b0; line_dp = '0; line_dm = '0;
        idle(3);
        check("reset tx_wr", tx_wr, 0);
        check("reset ports", {port_rst, port_ena}, 0);
        check("reset flags", {rsp_rdy, rsp_ovf, cmd_full}, 0);
        check("reset rsp_data", rsp_data, 0);
        reset = 1'b0;
        idle(2);

        // Port reset/enable only appear after the frame boundary
        push_cmd(16'h0403, 1'b1);
        idle(6);
        check("port before eof", {port_rst, port_ena}, 4'b0000);
        pulse_eof();
        check("port_rst after eof", port_rst, 2'b10);
        check("port_ena after eof", port_ena, 2'b10);
        m_pend_rst = 2'b10; m_pend_ena = 2'b10; m_port_rst = 2'b10; m_port_ena = 2'b10;

        // Line-state snapshot table
        for (int i = 0; i < 5; i++) begin
            line_dp = lv[i].dp; line_dm = lv[i].dm;
            push_cmd(16'h0200, 1'b0);
            idle(4);
            pop_rsp($sformatf("lines[%0d]", i), lv[i].exp);
        end

        // IN token with auto-ACK; rx while busy ignored; push+pop same cycle
        txq.delete();
        push_cmd(16'h7069, 1'b0);
        wait_txq(1, "token tx");
        idle(6);
        force_busy = 1'b1;
        send_rx(8'h11);
        force_busy = 1'b0;
        send_rx(8'hC3);
        check("rx word 1", {15'd0, rsp_rdy, rsp_data}, {15'd0, 1'b1, 16'h00C3});
        rx_data = 8'h5A; rx_rdy = 1'b1; rsp_rd = 1'b1;
        tick();
        rx_rdy = 1'b0; rsp_rd = 1'b0;
        check("push+pop head", {15'd0, rsp_rdy, rsp_data}, {15'd0, 1'b1, 16'h005A});
        rx_end = 1'b1; tick(); rx_end = 1'b0;
        wait_txq(3, "ack tx");
        idle(6);
        if (txq.size() >= 3) begin
            check("tx0", {txq[0].b, txq[0].l}, {8'h69, 1'b1});
            check("tx1 sync", {txq[1].b, txq[1].l}, {8'h80, 1'b0});
            check("tx2 ack", {txq[2].b, txq[2].l}, {8'hD2, 1'b1});
        end
        pop_rsp("rx word 2", 16'h005A);
        check("rsp drained", rsp_rdy, 0);

        // Packet command waits for frame_start
        txq.delete();
        push_cmd(16'hE0A5, 1'b0);
        idle(10);
        check("no tx before sof", txq.size(), 0);
        pulse_sof();
        idle(5);
        check("sof tx count", txq.size(), 1);
        if (txq.size() >= 1) check("sof tx byte", {txq[0].b, txq[0].l}, {8'hA5, 1'b1});

        // Response FIFO overflow: 33 snapshots, 32 kept
        line_dp = 2'b01; line_dm = 2'b10;
        for (int i = 0; i < 33; i++) push_cmd(16'h0200, 1'b0);
        idle(150);
        check("ovf sticky", rsp_ovf, 1);
        cnt = 0;
        while (rsp_rdy && cnt < 40) begin
            check("ovf word", rsp_data, 16'h4006);
            rsp_rd = 1'b1; tick(); rsp_rd = 1'b0;
            cnt++;
        end
        check("ovf stored", cnt, 32);

        // Randomized command stream against the reference model
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            ch = CHW'($urandom_range(0, NCH - 1));
            r = 1'($urandom); e = 1'($urandom); s = 1'($urandom);
            if (op == 0) begin
                push_cmd({14'h0100, e, r}, ch);
                m_pend_rst[ch] = r; m_pend_ena[ch] = e;
                idle(5);
                check("rnd chan_sel", chan_sel, ch);
            end else if (op == 1) begin
                dp = 2'($urandom); dm = 2'($urandom);
                line_dp = dp; line_dm = dm;
                cw = 16'h0200;
                if (s) cw = cw | 16'h0400 | {14'd0, e, r};
                push_cmd(cw, ch);
                if (s) begin m_pend_rst[ch] = r; m_pend_ena[ch] = e; end
                idle(5);
                pop_rsp("rnd lines", lines_word(dp, dm));
            end else begin
                pulse_eof();
                m_port_rst = m_pend_rst; m_port_ena = m_pend_ena;
                check("rnd ports", {port_rst, port_ena}, {m_port_rst, m_port_ena});
            end
        end

        // WAIT_RX with no reply
        txq.delete();
        push_cmd(16'h7069, 1'b1);
        wait_txq(1, "to token");
`ifdef USB11_MCTRL_RXTO_EN
        cnt = 0;
        while (!rsp_rdy && cnt < 300) begin tick(); cnt++; end
        if (!rsp_rdy) timeout_fail("rx timeout word");
        else begin
            check("timeout window", (cnt >= 95 && cnt <= 115), 1);
            pop_rsp("timeout word", 16'h8100);
        end
        check("no ack after timeout", txq.size(), 1);
`else
        idle(300);
        check("no timeout word", rsp_rdy, 0);
        pulse_eof();
`endif
        line_dp = 2'b11; line_dm = 2'b00;
        push_cmd(16'h0200, 1'b0);
        idle(5);
        pop_rsp("idle after wait_rx", 16'h400A);

        // Reset in the middle of a packet command
        txq.delete();
        push_cmd(16'hE011, 1'b0);
        idle(6);
        reset = 1'b1;
        #1;
        frame_start = 1'b1;
        #1;
        check("tx_wr in reset", tx_wr, 0);
        frame_start = 1'b0;
        idle(2);
        reset = 1'b0;
        tick();
        check("ovf cleared", rsp_ovf, 0);
        check("ports cleared", {port_rst, port_ena}, 0);
        pulse_sof();
        idle(5);
        check("aborted cmd silent", txq.size(), 0);

        // Command FIFO full: the 33rd write is dropped
        push_cmd(16'hE011, 1'b0);
        idle(6);
        line_dp = 2'b10; line_dm = 2'b01;
        cmd_data = 16'h0200; cmd_chan = 1'b0;
        for (int i = 0; i < 33; i++) begin cmd_wr = 1'b1; tick(); end
        cmd_wr = 1'b0;
        check("cmd_full", cmd_full, 1);
        n0 = txq.size();
        pulse_sof();
        idle(200);
        check("sof after full", txq.size(), n0 + 1);
        cnt = 0;
        while (rsp_rdy && cnt < 40) begin
            rsp_rd = 1'b1; tick(); rsp_rd = 1'b0;
            cnt++;
        end
        check("cmd fifo kept", cnt, 32);
        check("no rsp ovf", rsp_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_usb11_mctrl
`default_nettype wire
